oflow_mem_buffer_multi_port: RTL and testbench

Parametrised history-frame buffer for the oflow tracking core. It stores NUM_PORTS bounding-box records per cycle from the PE array into a ring of NUM_SLOTS frame slots. On request it replays the most recent history frames, newest first, one line of NUM_PORTS records at a time. Each line is paced by a ready handshake from the similarity-metric stage. Read/write sequencing, slot wrap-around and history counting are internal; the core FSM sees only start/done pulses.

---
 rtl/oflow_mem_buffer_pkg.sv | 24 ++
 rtl/oflow_mem_buffer_bank.sv | 28 ++
 rtl/oflow_mem_buffer_multi_port.sv | 223 ++++++++++++++++++++++
 tb/tb_oflow_mem_buffer_multi_port.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_mem_buffer_pkg.sv
// Shared types and sizing helpers for the oflow history-frame buffer.
// The localparams describe the default build; instances derive their own sizes via the helpers.
package oflow_mem_buffer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  function automatic int lines_per_slot(input int max_bbox, input int num_ports);
    return (max_bbox + num_ports - 1) / num_ports;
  endfunction

  function automatic int safe_clog2(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int LINES_PER_SLOT = lines_per_slot(32, 2);
  localparam int ADDR_W         = safe_clog2(5 * LINES_PER_SLOT);

endpackage

// File: rtl/oflow_mem_buffer_bank.sv
// Single-port RAM bank with registered read; one bank per lane holds records with record mod NUM_PORTS == lane.
module oflow_mem_buffer_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 80,
  parameter int ADDR_W     = 7
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read data only changes on an enabled read, so a line stays put while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      else      r_rdata       <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/oflow_mem_buffer_multi_port.sv
// History-frame ring buffer: stores lane-parallel bbox frames into NUM_SLOTS slots and
// replays the newest H frames, one NUM_PORTS-wide line per consumer handshake.
module oflow_mem_buffer_multi_port
  import oflow_mem_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PORTS  = 2,
  parameter int MAX_BBOX   = 32,
  parameter int NUM_SLOTS  = 5,
  parameter int BBOX_W     = $clog2(MAX_BBOX + 1),
  parameter int HIST_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                            clk,
  input  logic                            reset_N,
  input  logic                            start_write,
  input  logic                            start_read,
  input  logic [BBOX_W-1:0]               num_of_bbox_in_frame,
  input  logic [HIST_W-1:0]               num_of_history_frames,
  input  logic                            wr_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  input  logic                            read_new_line,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  output logic [NUM_PORTS-1:0]            lane_valid,
  output logic                            rd_valid,
  output logic                            done_write,
  output logic                            done_read,
  output logic [HIST_W-1:0]               counter_of_history_frame_to_interface,
  output logic                            busy,
  output logic                            cmd_err,
  output state_e                          o_dbg_state
);

  localparam int LPS    = lines_per_slot(MAX_BBOX, NUM_PORTS);
  localparam int AW     = safe_clog2(NUM_SLOTS * LPS);
  localparam int SLOT_W = safe_clog2(NUM_SLOTS);
  localparam int LINE_W = safe_clog2(LPS + 1);
  localparam int CNT_W  = $clog2(MAX_BBOX + 2 * NUM_PORTS + 1) + 1;

  state_e              r_state;
  logic                r_op_write;
  logic [BBOX_W-1:0]   r_n;
  logic [LINE_W-1:0]   r_wline;
  logic [SLOT_W-1:0]   r_wr_slot;
  logic [HIST_W-1:0]   r_valid_frames;
  logic [BBOX_W-1:0]   r_slot_count [NUM_SLOTS];
  logic [HIST_W-1:0]   r_h;
  logic [HIST_W-1:0]   r_k;
  logic [SLOT_W-1:0]   r_rd_slot;
  logic [LINE_W-1:0]   r_line;
  logic [NUM_PORTS-1:0] r_lane_valid;
  logic                r_rd_valid;
  logic                r_done_write;
  logic                r_done_read;
  logic                r_cmd_err;

  logic [CNT_W-1:0]    w_wr_rec;
  logic [CNT_W-1:0]    w_rd_rec;
  logic [CNT_W-1:0]    w_n_ext;
  logic [CNT_W-1:0]    w_cur_cnt;
  logic                w_wr_last;
  logic                w_rd_last_line;
  logic [HIST_W-1:0]   w_hist_clamp;
  logic                w_wr_fire;
  logic                w_issue;
  logic [AW-1:0]       w_bank_addr;
  logic [NUM_PORTS-1:0] w_lane_next;

  function automatic logic [SLOT_W-1:0] slot_dec(input logic [SLOT_W-1:0] s);
    return (s == '0) ? SLOT_W'(NUM_SLOTS - 1) : s - SLOT_W'(1);
  endfunction

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(NUM_SLOTS - 1)) ? '0 : s + SLOT_W'(1);
  endfunction

  assign w_wr_rec       = CNT_W'(r_wline) * CNT_W'(NUM_PORTS);
  assign w_rd_rec       = CNT_W'(r_line) * CNT_W'(NUM_PORTS);
  assign w_n_ext        = CNT_W'(r_n);
  assign w_cur_cnt      = CNT_W'(r_slot_count[r_rd_slot]);
  assign w_wr_last      = (w_wr_rec + CNT_W'(NUM_PORTS)) >= w_n_ext;
  assign w_rd_last_line = (w_rd_rec + CNT_W'(NUM_PORTS)) >= w_cur_cnt;
  assign w_hist_clamp   = (num_of_history_frames > r_valid_frames) ? r_valid_frames
                                                                   : num_of_history_frames;
  assign w_wr_fire      = (r_state == S_WRITE) && wr_valid;
  assign w_issue        = (r_state == S_RD_ISSUE) && (w_cur_cnt != '0);
  assign w_bank_addr    = (r_state == S_WRITE)
                          ? AW'(r_wr_slot) * AW'(LPS) + AW'(r_wline)
                          : AW'(r_rd_slot) * AW'(LPS) + AW'(r_line);

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_lane
      logic                  w_we;
      logic [DATA_WIDTH-1:0] w_rdata;

      assign w_we           = w_wr_fire && ((w_wr_rec + CNT_W'(g)) < w_n_ext);
      assign w_lane_next[g] = (w_rd_rec + CNT_W'(g)) < w_cur_cnt;

      oflow_mem_buffer_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_SLOTS * LPS),
        .ADDR_W     (AW)
      ) u_bank (
        .i_clk   (clk),
        .i_en    (w_we | w_issue),
        .i_we    (w_we),
        .i_addr  (w_bank_addr),
        .i_wdata (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
        .o_rdata (w_rdata)
      );

      assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = r_lane_valid[g] ? w_rdata : '0;
    end
  endgenerate

  // Handshake: a line is offered while rd_valid=1 and is consumed on a clock edge where
  // read_new_line=1; rd_valid then drops for the one-cycle re-issue gap before the next line.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      r_state        <= S_IDLE;
      r_op_write     <= 1'b0;
      r_n            <= '0;
      r_wline        <= '0;
      r_wr_slot      <= '0;
      r_valid_frames <= '0;
      r_h            <= '0;
      r_k            <= '0;
      r_rd_slot      <= '0;
      r_line         <= '0;
      r_lane_valid   <= '0;
      r_rd_valid     <= 1'b0;
      r_done_write   <= 1'b0;
      r_done_read    <= 1'b0;
      r_cmd_err      <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) r_slot_count[s] <= '0;
    end else begin
      r_done_write <= 1'b0;
      r_done_read  <= 1'b0;
      r_cmd_err    <= (r_state != S_IDLE) && (start_write || start_read);
      case (r_state)
        S_IDLE: begin
          if (start_write) begin
            r_op_write <= 1'b1;
            r_n        <= num_of_bbox_in_frame;
            r_wline    <= '0;
            r_cmd_err  <= start_read;
            r_state    <= (num_of_bbox_in_frame == '0) ? S_DONE : S_WRITE;
          end else if (start_read) begin
            r_op_write <= 1'b0;
            r_h        <= w_hist_clamp;
            r_k        <= (w_hist_clamp == '0) ? '0 : HIST_W'(1);
            r_line     <= '0;
            r_rd_slot  <= slot_dec(r_wr_slot);
            r_state    <= (w_hist_clamp == '0) ? S_DONE : S_RD_ISSUE;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            r_wline <= r_wline + LINE_W'(1);
            if (w_wr_last) r_state <= S_DONE;
          end
        end
        S_RD_ISSUE: begin
          if (w_cur_cnt == '0) begin
            // Empty frame slot: skip it without presenting any line.
            if (r_k == r_h) begin
              r_state <= S_DONE;
            end else begin
              r_k       <= r_k + HIST_W'(1);
              r_rd_slot <= slot_dec(r_rd_slot);
              r_line    <= '0;
            end
          end else begin
            r_rd_valid   <= 1'b1;
            r_lane_valid <= w_lane_next;
            r_state      <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (read_new_line) begin
            r_rd_valid <= 1'b0;
            if (!w_rd_last_line) begin
              r_line  <= r_line + LINE_W'(1);
              r_state <= S_RD_ISSUE;
            end else if (r_k == r_h) begin
              r_state <= S_DONE;
            end else begin
              r_k       <= r_k + HIST_W'(1);
              r_rd_slot <= slot_dec(r_rd_slot);
              r_line    <= '0;
              r_state   <= S_RD_ISSUE;
            end
          end
        end
        S_DONE: begin
          if (r_op_write) begin
            r_done_write              <= 1'b1;
            r_slot_count[r_wr_slot]   <= r_n;
            r_wr_slot                 <= slot_inc(r_wr_slot);
            if (r_valid_frames != HIST_W'(NUM_SLOTS))
              r_valid_frames <= r_valid_frames + HIST_W'(1);
          end else begin
            r_done_read <= 1'b1;
          end
          r_k          <= '0;
          r_lane_valid <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lane_valid                            = r_lane_valid;
  assign rd_valid                              = r_rd_valid;
  assign done_write                            = r_done_write;
  assign done_read                             = r_done_read;
  assign counter_of_history_frame_to_interface = r_k;
  assign busy                                  = (r_state != S_IDLE);
  assign cmd_err                               = r_cmd_err;
  assign o_dbg_state                           = r_state;

endmodule

// File: tb/tb_oflow_mem_buffer_multi_port.sv
// Directed bench for the history-frame buffer: expected lines are queued at stimulus time
// and a negedge monitor pops and compares each line the consumer accepts.
module tb_oflow_mem_buffer_multi_port;
  import oflow_mem_buffer_pkg::*;

  localparam int DW    = 64;
  localparam int NP    = 2;
  localparam int MAXB  = 32;
  localparam int NSLOT = 5;
  localparam int BW    = $clog2(MAXB + 1);
  localparam int HW    = $clog2(NSLOT + 1);
  localparam int EW    = HW + NP + NP * DW;

  logic              clk = 1'b0;
  logic              reset_N = 1'b1;
  logic              start_write = 1'b0;
  logic              start_read = 1'b0;
  logic [BW-1:0]     num_of_bbox_in_frame = '0;
  logic [HW-1:0]     num_of_history_frames = '0;
  logic              wr_valid = 1'b0;
  logic [NP*DW-1:0]  data_in = '0;
  logic              read_new_line = 1'b0;
  logic [NP*DW-1:0]  data_out;
  logic [NP-1:0]     lane_valid;
  logic              rd_valid;
  logic              done_write;
  logic              done_read;
  logic [HW-1:0]     counter;
  logic              busy;
  logic              cmd_err;
  state_e            dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_accepted = 0;

  // reference model of the ring
  int m_wr_slot = 0;
  int m_valid = 0;
  int m_count [NSLOT];
  int m_frame [NSLOT];

  oflow_mem_buffer_multi_port #(
    .DATA_WIDTH (DW), .NUM_PORTS (NP), .MAX_BBOX (MAXB), .NUM_SLOTS (NSLOT)
  ) dut (
    .clk                                   (clk),
    .reset_N                               (reset_N),
    .start_write                           (start_write),
    .start_read                            (start_read),
    .num_of_bbox_in_frame                  (num_of_bbox_in_frame),
    .num_of_history_frames                 (num_of_history_frames),
    .wr_valid                              (wr_valid),
    .data_in                               (data_in),
    .read_new_line                         (read_new_line),
    .data_out                              (data_out),
    .lane_valid                            (lane_valid),
    .rd_valid                              (rd_valid),
    .done_write                            (done_write),
    .done_read                             (done_read),
    .counter_of_history_frame_to_interface (counter),
    .busy                                  (busy),
    .cmd_err                               (cmd_err),
    .o_dbg_state                           (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rec(input int f, input int r);
    logic [31:0] fv;
    logic [31:0] rv;
    fv = f;
    rv = r;
    return {16'hB0B0, fv[15:0], rv};
  endfunction

  task automatic check_quiet_outputs(input string name);
    check(name, {data_out, lane_valid, rd_valid, done_write, done_read, counter, busy, cmd_err}, '0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rd_valid && read_new_line) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_line: got line %0h with no line required", data_out);
      end else begin
        check("line", {counter, lane_valid, data_out}, exp_q.pop_front());
      end
      n_accepted++;
    end
  end

  task automatic model_commit(input int f, input int n);
    m_count[m_wr_slot] = n;
    m_frame[m_wr_slot] = f;
    m_wr_slot = (m_wr_slot + 1) % NSLOT;
    if (m_valid < NSLOT) m_valid++;
  endtask

  task automatic wait_done_write(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (done_write) seen = 1'b1;
      else tick;
    end
    check(name, seen, 1'b1);
  endtask

  // driver: one frame of n records for frame id f
  task automatic write_frame(input int f, input int n, input bit stall);
    start_write = 1'b1;
    num_of_bbox_in_frame = BW'(n);
    tick;
    start_write = 1'b0;
    for (int a = 0; a < n; a += NP) begin
      if (stall) repeat ($urandom_range(0, 2)) tick;
      wr_valid = 1'b1;
      for (int i = 0; i < NP; i++)
        data_in[i*DW +: DW] = (a + i < n) ? rec(f, a + i) : {DW{1'b1}};
      tick;
      wr_valid = 1'b0;
    end
    wait_done_write("done_write");
    model_commit(f, n);
  endtask

  // driver: request h_req frames; hold_at >= 0 stalls the consumer 10 cycles on that line
  task automatic read_history(input int h_req, input int hold_at);
    int h, slot, cnt, nlines, base_acc, done_at, hold_cnt;
    bit got_done, saw_rv;
    logic [EW-1:0] e;
    logic [EW-1:0] held;
    logic [HW-1:0] kv;
    logic [NP-1:0] lv;
    logic [NP*DW-1:0] dv;
    h = (h_req < m_valid) ? h_req : m_valid;
    nlines = 0;
    for (int k = 1; k <= h; k++) begin
      slot = (m_wr_slot + NSLOT - k) % NSLOT;
      cnt = m_count[slot];
      for (int l = 0; l * NP < cnt; l++) begin
        kv = HW'(k);
        lv = '0;
        dv = '0;
        for (int i = 0; i < NP; i++) begin
          if (l * NP + i < cnt) begin
            lv[i] = 1'b1;
            dv[i*DW +: DW] = rec(m_frame[slot], l * NP + i);
          end
        end
        e = {kv, lv, dv};
        exp_q.push_back(e);
        nlines++;
      end
    end
    base_acc = n_accepted;
    start_read = 1'b1;
    num_of_history_frames = HW'(h_req);
    tick;
    start_read = 1'b0;
    got_done = 1'b0;
    saw_rv = 1'b0;
    done_at = -1;
    hold_cnt = 0;
    held = '0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      if (done_read) begin
        got_done = 1'b1;
        done_at = c;
      end else begin
        if (rd_valid) saw_rv = 1'b1;
        if (rd_valid && (n_accepted - base_acc) == hold_at && hold_cnt < 10) begin
          read_new_line = 1'b0;
          if (hold_cnt == 0) held = {counter, lane_valid, data_out};
          else check("hold_stable", {rd_valid, counter, lane_valid, data_out}, {1'b1, held});
          hold_cnt++;
        end else begin
          read_new_line = 1'b1;
        end
        tick;
      end
    end
    read_new_line = 1'b0;
    check("done_read", got_done, 1'b1);
    check("lines_accepted", n_accepted - base_acc, nlines);
    check("queue_drained", exp_q.size(), 0);
    check("counter_idle", counter, '0);
    if (h == 0) begin
      check("empty_done_latency", done_at, 1);
      check("empty_no_rd_valid", saw_rv, 1'b0);
    end
    tick;
  endtask

  initial begin
    for (int s = 0; s < NSLOT; s++) begin
      m_count[s] = 0;
      m_frame[s] = 0;
    end
    repeat (3) tick;
    check_quiet_outputs("reset_outputs");
    reset_N = 1'b0;
    tick;

    // empty history after reset
    read_history(4, -1);

    // empty frame, then three 5-record frames replayed newest first
    write_frame(0, 0, 1'b0);
    write_frame(1, 5, 1'b0);
    write_frame(2, 5, 1'b1);
    write_frame(3, 5, 1'b0);
    read_history(3, -1);
    read_history(4, -1);

    // consumer stall mid-frame
    read_history(2, 1);

    // both starts together, then start_read during WRITE
    start_write = 1'b1;
    start_read = 1'b1;
    num_of_bbox_in_frame = BW'(3);
    num_of_history_frames = HW'(2);
    tick;
    start_write = 1'b0;
    start_read = 1'b0;
    check("cmd_err_both", {cmd_err, busy}, 2'b11);
    wr_valid = 1'b1;
    data_in = {rec(4, 1), rec(4, 0)};
    tick;
    check("cmd_err_clear", cmd_err, 1'b0);
    start_read = 1'b1;
    data_in = {{DW{1'b1}}, rec(4, 2)};
    tick;
    start_read = 1'b0;
    wr_valid = 1'b0;
    check("cmd_err_in_write", cmd_err, 1'b1);
    wait_done_write("done_write_cmd");
    model_commit(4, 3);
    check("rd_valid_after_cmd", rd_valid, 1'b0);

    // ring wrap and history clamp
    write_frame(5, 7, 1'b1);
    write_frame(6, 2, 1'b0);
    write_frame(7, 4, 1'b0);
    read_history(7, -1);

    // reset during a write discards the frame and the history
    start_write = 1'b1;
    num_of_bbox_in_frame = BW'(6);
    tick;
    start_write = 1'b0;
    for (int a = 0; a < 4; a += NP) begin
      wr_valid = 1'b1;
      data_in = {rec(9, a + 1), rec(9, a)};
      tick;
    end
    wr_valid = 1'b0;
    reset_N = 1'b1;
    tick;
    check_quiet_outputs("reset_mid_write");
    reset_N = 1'b0;
    m_wr_slot = 0;
    m_valid = 0;
    tick;
    read_history(4, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
